// File: rtl/cam_i2c_arbiter_if.sv
// Bundles both requester handshakes and the I2C write-controller bus that the
// arbiter sits between.
interface cam_i2c_arbiter_if;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req0_done;
  logic        req0_err;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        req1_done;
  logic        req1_err;
  logic [23:0] ctl_data;
  logic        ctl_enable;
  logic        ctl_ack;
  logic        ctl_end;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, ctl_ack, ctl_end,
    output req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err,
    output ctl_data, ctl_enable
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, ctl_ack, ctl_end,
    input  req0_ready, req0_done, req0_err, req1_ready, req1_done, req1_err,
    input  ctl_data, ctl_enable
  );
endinterface

// File: rtl/cam_i2c_arbiter.sv
// Round-robin arbiter sharing one SCCB/I2C write controller between the power-up
// sequencer and runtime register writers; handles delay commands, NACK retry and timeout.
module cam_i2c_arbiter #(
  parameter logic [7:0] DEV_ADDR       = 8'h42,
  parameter int         MAX_RETRY      = 3,
  parameter int         DELAY_CYCLES   = 20000,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  cam_i2c_arbiter_if.master bus,
  output logic              busy,
  output logic              grant,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_END, S_RELEASE, S_GUARD, S_DELAY, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [1:0] {R_OK, R_RETRY, R_FAIL} result_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] DELAY_LAST   = 16'(DELAY_CYCLES - 1);
  localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRY);

  state_t      state, state_nx;
  result_t     result;
  logic        owner, prefer, take, pick;
  logic [2:0]  retry;
  logic [15:0] timer, data_q, pick_data;

  always_comb begin
    state_nx  = state;
    take      = 1'b0;
    pick      = prefer;
    pick_data = bus.req0_data;
    case (state)
      S_IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          take = 1'b1;
          pick = prefer;
        end else if (bus.req0_valid) begin
          take = 1'b1;
          pick = 1'b0;
        end else if (bus.req1_valid) begin
          take = 1'b1;
          pick = 1'b1;
        end
        pick_data = pick ? bus.req1_data : bus.req0_data;
        if (take) state_nx = (pick_data[15:8] == 8'hFF) ? S_DELAY : S_ISSUE;
      end
      S_ISSUE:    state_nx = S_WAIT_END;
      S_WAIT_END: if (bus.ctl_end || timer == TIMEOUT_LAST) state_nx = S_RELEASE;
      S_RELEASE:  if (!bus.ctl_end) state_nx = S_GUARD;
      S_GUARD: begin
        case (result)
          R_OK:    state_nx = S_DONE;
          R_RETRY: state_nx = S_ISSUE;
          default: state_nx = S_ERROR;
        endcase
      end
      S_DELAY:    if (timer == DELAY_LAST) state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
      S_ERROR:    state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase

    bus.req0_ready = take && !pick;
    bus.req1_ready = take && pick;
    bus.req0_done  = (state == S_DONE)  && !owner;
    bus.req1_done  = (state == S_DONE)  && owner;
    bus.req0_err   = (state == S_ERROR) && !owner;
    bus.req1_err   = (state == S_ERROR) && owner;
    bus.ctl_enable = (state == S_ISSUE) || (state == S_WAIT_END);
    // ctl_data is only presented while a transfer owns the bus, zero otherwise
    bus.ctl_data   = (state inside {S_ISSUE, S_WAIT_END, S_RELEASE, S_GUARD}) ?
                     {DEV_ADDR, data_q} : 24'h0;
    busy           = (state != S_IDLE);
  end

  assign grant = owner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      owner     <= 1'b0;
      prefer    <= 1'b0;
      retry     <= 3'd0;
      timer     <= 16'd0;
      result    <= R_OK;
      err_count <= 8'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (take) begin
            owner <= pick;
            retry <= 3'd0;
            timer <= 16'd0;
          end
        end
        S_ISSUE: timer <= 16'd0;
        S_WAIT_END: begin
          timer <= timer + 16'd1;
          // a reported end always wins over a timeout landing in the same cycle
          if (bus.ctl_end && !bus.ctl_ack) begin
            result <= R_OK;
          end else if (bus.ctl_end || timer == TIMEOUT_LAST) begin
            if (retry < RETRY_LIMIT) begin
              retry  <= retry + 3'd1;
              result <= R_RETRY;
            end else begin
              result <= R_FAIL;
            end
          end
        end
        S_DELAY: timer <= timer + 16'd1;
        S_DONE:  prefer <= ~owner;
        S_ERROR: begin
          prefer <= ~owner;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && take) data_q <= pick_data;
  end

endmodule

// File: doc/cam_i2c_arbiter.md
Name: cam_i2c_arbiter

Overview:
- Shares the single camera SCCB/I2C write controller between two requesters:
  - requester 0: the power-up configuration sequencer;
  - requester 1: runtime register writers, e.g. exposure/gain tuning.
- Arbitrates round-robin and sequences one 3-byte write per grant.
- Handles the 0xFF delay pseudo-command, NACK retry and a stuck-bus timeout.
- Runs in the I2C control clock domain, between the requesters and the I2C controller instance.

Parameters:
- DEV_ADDR, 8'h42: device write address placed in ctl_data[23:16].
- MAX_RETRY, 3: extra attempts after a NACK or timeout before reporting an error (range 0..7).
- DELAY_CYCLES, 20000: clk cycles waited for a delay command (register byte 8'hFF).
- TIMEOUT_CYCLES, 4096: clk cycles allowed from ctl_enable rise to ctl_end.

Ports:
- clk, in, 1: I2C control clock; the single clock of this block.
- reset, in, 1: asynchronous, active-low reset.
- req0_valid, in, 1: requester 0 has a command; must stay high and stable until req0_ready.
- req0_data, in, 16: {register address, value}.
- req0_ready, out, 1: 1-cycle accept pulse.
- req0_done, out, 1: 1-cycle pulse on success.
- req0_err, out, 1: 1-cycle pulse when retries are exhausted.
- req1_valid, req1_data, req1_ready, req1_done, req1_err: same as requester 0, for requester 1.
- ctl_data, out, 24: {DEV_ADDR, reg, value} to the controller.
- ctl_enable, out, 1: starts a transfer; held high until ctl_end.
- ctl_ack, in, 1: sampled with ctl_end; 0 = all bytes ACKed, 1 = NACK.
- ctl_end, in, 1: transfer finished; level, stays high while ctl_enable is high.
- busy, out, 1: high in any state other than IDLE.
- grant, out, 1: index of the current or last owner.
- err_count, out, 8: saturating count of err pulses.

Behaviour:
- Reset (async, active-low): all outputs 0. State = IDLE, retry counter 0, timer 0, grant 0, round-robin pointer prefers requester 0.

State IDLE:
- Neither valid: stay in IDLE.
- One valid: grant it.
- Both valid: grant the requester other than the last owner; the first arbitration after reset picks requester 0.
- On grant:
  - latch data and owner;
  - pulse that requester's ready for 1 cycle;
  - clear the retry counter.
- Go to DELAY if the latched reg byte is 8'hFF, else go to ISSUE.

State ISSUE (1 cycle):
- Drive ctl_data = {DEV_ADDR, latched data}.
- Set ctl_enable = 1.
- Clear the timer; go to WAIT_END.

State WAIT_END:
- ctl_enable held at 1; timer increments each cycle.
- ctl_end = 1 and ctl_ack = 0: success, go to RELEASE.
- ctl_end = 1 and ctl_ack = 1: failure.
- Timer reaches TIMEOUT_CYCLES-1 without ctl_end: failure.
- ctl_end takes precedence over timeout when both occur in the same cycle.

On failure:
- Retry counter < MAX_RETRY: increment it, go to RELEASE, then re-ISSUE.
- Otherwise: go to RELEASE, then report the error.

State RELEASE:
- ctl_enable = 0; stay until ctl_end = 0.
- Then wait 1 guard cycle.
- Then exactly one of:
  - go to DONE (success);
  - re-enter ISSUE (retry);
  - go to ERROR (retries exhausted).

State DELAY:
- No bus activity; ctl_enable stays 0.
- Timer counts 0..DELAY_CYCLES-1, then go to DONE.

State DONE:
- Pulse the owner's done for 1 cycle; update the round-robin pointer; go to IDLE.

State ERROR:
- Pulse the owner's err for 1 cycle.
- err_count increments, saturating at 255.
- Update the round-robin pointer; go to IDLE.

Timing and fixed rules:
- Accept-to-enable latency: ready pulses in the IDLE cycle; ctl_enable rises on the next cycle (ISSUE).
- Success path back to IDLE: ctl_end low → guard cycle → DONE → IDLE, so a new grant is possible at the earliest 3 cycles after ctl_end falls.
- ctl_data is stable from ISSUE until RELEASE exits.
- Data changes on valid while the block is busy are ignored, because data is latched at grant.
- A requester deasserting valid before ready is legal; no grant occurs.
- At most one of ready/done/err pulses per cycle, and only for the owner.
- Reset asserted mid-transfer: immediate return to reset values, including ctl_enable = 0; no done/err pulse.
- Timer is 16 bits wide.

Test Plan:
- Single write: req0 with 16'h12_04 → ctl_data = 24'h42_12_04; ctl_enable high until ctl_end; ack=0 gives req0_done = 1 once; err_count = 0.
- Contention: req0 and req1 valid together from reset → order req0, req1, req0 (alternating); each ready precedes the matching done; no overlapping ctl_enable.
- NACK retry: ack=1 on 2 attempts then ack=0 → exactly 3 ctl_enable pulses, then done. With MAX_RETRY=3 and always NACK → 4 attempts, req_err pulse, err_count = 1.
- Timeout: ctl_end held 0 → ctl_enable drops after TIMEOUT_CYCLES; counts as a retry; 4 timeouts give err.
- Delay command: req1 with 16'hFF_F0 and DELAY_CYCLES=20 → no ctl_enable; req1_done exactly 21 cycles after req1_ready.
- Reset mid WAIT_END: assert reset → ctl_enable = 0 and busy = 0 asynchronously; next request is granted to requester 0 normally.
